cluster_w_aligner: RTL and testbench
====================================

// Module: cluster_w_aligner
// PURPOSE
//  Write-data lockstep stage between the NrClusters Ara cluster W channels and the global
//  load/store unit. Buffers each cluster's W beats in a private FIFO. Releases one merged beat
//  (all clusters' data side by side) only when every cluster has a beat pending.
//  Removes the downstream dependence on cluster 0's w_valid being representative of all clusters.
// PARAMETERS
//  NrClusters          4   number of clusters (power of 2, >=2)
//  ClusterAxiDataWidth 64  per-cluster W data width in bits (strb = /8)
//  UserWidth           1   AXI W user width
//  FifoDepth           4   beats buffered per cluster (power of 2, >=2)
// PORTS
//  clk_i         in   1                        clock
//  rst_ni        in   1                        reset, asynchronous, active-low
//  flush_i       in   1                        sync clear of all FIFOs, counters, error
//  cl_w_data_i   in   NrClusters*CDW           per-cluster W data, cluster i at [i*CDW +: CDW]
//  cl_w_strb_i   in   NrClusters*CDW/8         per-cluster W strobes, same packing
//  cl_w_last_i   in   NrClusters               per-cluster W last
//  cl_w_user_i   in   NrClusters*UserWidth     per-cluster W user
//  cl_w_valid_i  in   NrClusters               per-cluster W valid
//  cl_w_ready_o  out  NrClusters               per-cluster W ready
//  mw_data_o     out  NrClusters*CDW           merged data, cluster i at [i*CDW +: CDW]
//  mw_strb_o     out  NrClusters*CDW/8         merged strobes
//  mw_last_o     out  1                        merged last (= cluster 0 last)
//  mw_user_o     out  UserWidth                merged user (= cluster 0 user)
//  mw_valid_o    out  1                        merged beat valid
//  mw_ready_i    in   1                        downstream ready
//  mw_beat_cnt_o out  8                        beats popped in current burst
//  error_o       out  1                        sticky last-mismatch flag
// BEHAVIOUR
//  Reset: all FIFOs empty, cl_w_ready_o='1, mw_valid_o=0, mw_beat_cnt_o=0, error_o=0.
//  Push: cluster i writes on cl_w_valid_i[i] & cl_w_ready_o[i].
//  cl_w_ready_o[i] = (count_i != FifoDepth). Ready depends on count only; no same-cycle pop->push bypass.
//  No fall-through: a beat pushed at edge N is visible on mw_* from cycle N+1. Minimum latency is 1.
//  mw_valid_o = AND over i of (count_i != 0). mw_* are driven by the FIFO heads and are stable while valid & !ready.
//  Pop: on mw_valid_o & mw_ready_i, every FIFO pops its head in the same cycle.
//  Never a partial pop.
//  Simultaneous push+pop on one FIFO: count is unchanged and pointers both advance.
//    This is legal at any count except push-when-full, which ready prevents.
//  Pointers are log2(FifoDepth) bits and wrap naturally; count is log2(FifoDepth)+1 bits.
//  mw_beat_cnt_o increments on each pop and wraps at 255.
//    On a pop with mw_last_o=1 it goes to 0 instead.
//  flush_i has priority over push/pop in that cycle: counts, pointers, beat_cnt and error go to 0.
//  rst_ni asserted mid-burst: all in-flight beats are dropped, and state returns to reset values asynchronously.
// CONFIGURATION
//  Macro CLUSTER_W_ALIGNER_LAST_CHECK_EN:
//   defined: at each pop, if cl heads' last bits are not all equal, error_o sets (sticky)
//     until flush_i or reset. The pop proceeds normally.
//   undefined: no compare logic; error_o tied to 1'b0.
// STRUCTURE
//  Shared package (ara_pkg): cluster_w_beat_t {data[CDW], strb[CDW/8], last, user}
//    and localparam CDW = ClusterAxiDataWidth.
//  Sub-module cluster_w_fifo: one instance per cluster, depth FifoDepth, payload cluster_w_beat_t.
//    Ports: push, pop, flush, head, count.
//  Top level: generate loop of FIFOs, AND-reduce of non-empty, pop broadcast,
//    beat counter, optional last compare.
// TESTING (NrClusters=4, CDW=64, FifoDepth=4)
//  1. Push one beat per cluster in the same cycle (data=i+1), mw_ready_i=1
//     -> mw_valid_o=1 next cycle, mw_data_o=0x4_3_2_1 (64-bit lanes), FIFOs empty after pop.
//  2. Clusters 0..2 push 1 beat each, cluster 3 pushes 3 cycles later
//     -> mw_valid_o stays 0 until the cycle after cluster 3's push, then exactly one merged beat.
//  3. mw_ready_i=0, each cluster pushes 5 beats -> 4 accepted per cluster, cl_w_ready_o=0 after the 4th.
//     Then raise mw_ready_i -> 4 pops on consecutive cycles, data in order.
//  4. Burst of 3 beats, last on beat 3 for all clusters
//     -> mw_beat_cnt_o reads 0,1,2 during the pops, 0 after, mw_last_o=1 on the 3rd pop only.
//  5. (macro defined) cluster 2 last=1 while others last=0
//     -> error_o=1 the cycle after the pop and stays 1; flush_i=1 for 1 cycle -> error_o=0,
//     mw_valid_o=0, cl_w_ready_o='1.
//  6. Fill 2 beats per cluster, assert rst_ni=0 mid-stream
//     -> mw_valid_o=0 and cl_w_ready_o='1 immediately, no stale beats after release.

Source files
------------

// File: rtl/ara_pkg.sv
// ara_pkg: shared cluster W beat type and width constants for the write-data path.
package ara_pkg;
  localparam int ClusterAxiDataWidth = 64;
  localparam int CDW = ClusterAxiDataWidth;
  localparam int UserWidth = 1;
  typedef struct packed {
    logic [CDW-1:0]       data;
    logic [CDW/8-1:0]     strb;
    logic                 last;
    logic [UserWidth-1:0] user;
  } cluster_w_beat_t;
endpackage

// File: rtl/cluster_w_aligner_fifo.sv
// cluster_w_fifo: per-cluster W beat buffer, no fall-through, head registered from storage.
module cluster_w_fifo import ara_pkg::*; #(
  parameter int Depth = 4,
  localparam int AW = $clog2(Depth)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush,
  input  logic            push,
  input  logic            pop,
  input  cluster_w_beat_t din,
  output cluster_w_beat_t head,
  output logic [AW:0]     count
);
  cluster_w_beat_t mem [Depth];
  logic [AW-1:0] wptr, rptr;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end
  always_ff @(posedge clk_i) begin
    if (push) mem[wptr] <= din;
  end
  assign head = mem[rptr];
endmodule

// File: rtl/cluster_w_aligner.sv
// cluster_w_aligner: merges per-cluster W beats in lockstep; optional last compare via CLUSTER_W_ALIGNER_LAST_CHECK_EN.
module cluster_w_aligner import ara_pkg::*; #(
  parameter int NrClusters          = 4,
  parameter int ClusterAxiDataWidth = ara_pkg::ClusterAxiDataWidth,
  parameter int UserWidth           = ara_pkg::UserWidth,
  parameter int FifoDepth           = 4
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   flush_i,
  input  logic [NrClusters*ClusterAxiDataWidth-1:0]   cl_w_data_i,
  input  logic [NrClusters*ClusterAxiDataWidth/8-1:0] cl_w_strb_i,
  input  logic [NrClusters-1:0]                  cl_w_last_i,
  input  logic [NrClusters*UserWidth-1:0]        cl_w_user_i,
  input  logic [NrClusters-1:0]                  cl_w_valid_i,
  output logic [NrClusters-1:0]                  cl_w_ready_o,
  output logic [NrClusters*ClusterAxiDataWidth-1:0]   mw_data_o,
  output logic [NrClusters*ClusterAxiDataWidth/8-1:0] mw_strb_o,
  output logic                                   mw_last_o,
  output logic [UserWidth-1:0]                   mw_user_o,
  output logic                                   mw_valid_o,
  input  logic                                   mw_ready_i,
  output logic [7:0]                             mw_beat_cnt_o,
  output logic                                   error_o
);
  localparam int DW = ClusterAxiDataWidth;
  localparam int SW = DW / 8;
  localparam int AW = $clog2(FifoDepth);
  cluster_w_beat_t heads [NrClusters];
  logic [NrClusters-1:0] nonempty, push;
  logic pop;
  for (genvar i = 0; i < NrClusters; i++) begin : g_fifo
    logic [AW:0] count;
    cluster_w_fifo #(.Depth(FifoDepth)) u_fifo (
      .clk_i,
      .rst_ni,
      .flush (flush_i),
      .push  (push[i]),
      .pop,
      .din   ({cl_w_data_i[i*DW +: DW], cl_w_strb_i[i*SW +: SW], cl_w_last_i[i],
               cl_w_user_i[i*UserWidth +: UserWidth]}),
      .head  (heads[i]),
      .count
    );
    assign cl_w_ready_o[i]         = count != (AW+1)'(FifoDepth);
    assign push[i]                 = cl_w_valid_i[i] & cl_w_ready_o[i];
    assign nonempty[i]             = count != '0;
    assign mw_data_o[i*DW +: DW]   = heads[i].data;
    assign mw_strb_o[i*SW +: SW]   = heads[i].strb;
  end
  assign mw_valid_o = &nonempty;
  assign mw_last_o  = heads[0].last;
  assign mw_user_o  = heads[0].user;
  assign pop        = mw_valid_o & mw_ready_i;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) mw_beat_cnt_o <= '0;
    else if (flush_i) mw_beat_cnt_o <= '0;
    else if (pop) mw_beat_cnt_o <= mw_last_o ? 8'd0 : mw_beat_cnt_o + 8'd1;
  end
`ifdef CLUSTER_W_ALIGNER_LAST_CHECK_EN
  logic [NrClusters-1:0] lasts;
  for (genvar i = 0; i < NrClusters; i++) begin : g_last
    assign lasts[i] = heads[i].last;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) error_o <= 1'b0;
    else if (flush_i) error_o <= 1'b0;
    else if (pop && !(&lasts || ~|lasts)) error_o <= 1'b1;
  end
`else
  assign error_o = 1'b0;
`endif
endmodule

// File: tb/tb_cluster_w_aligner.sv
// tb_cluster_w_aligner: scoreboard bench; per-cluster model queues checked against merged output.
module tb_cluster_w_aligner;
  localparam int N = 4;
  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
    logic        user;
  } beat_t;
  logic         clk = 1'b0;
  logic         rst_ni = 1'b0;
  logic         flush = 1'b0;
  logic [255:0] cl_w_data_i = '0;
  logic [31:0]  cl_w_strb_i = '0;
  logic [3:0]   cl_w_last_i = '0;
  logic [3:0]   cl_w_user_i = '0;
  logic [3:0]   cl_w_valid_i = '0;
  logic [3:0]   cl_w_ready_o;
  logic [255:0] mw_data_o;
  logic [31:0]  mw_strb_o;
  logic         mw_last_o;
  logic [0:0]   mw_user_o;
  logic         mw_valid_o;
  logic         mw_ready_i = 1'b0;
  logic [7:0]   mw_beat_cnt_o;
  logic         error_o;
  cluster_w_aligner dut (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush),
    .cl_w_data_i(cl_w_data_i), .cl_w_strb_i(cl_w_strb_i), .cl_w_last_i(cl_w_last_i),
    .cl_w_user_i(cl_w_user_i), .cl_w_valid_i(cl_w_valid_i), .cl_w_ready_o(cl_w_ready_o),
    .mw_data_o(mw_data_o), .mw_strb_o(mw_strb_o), .mw_last_o(mw_last_o), .mw_user_o(mw_user_o),
    .mw_valid_o(mw_valid_o), .mw_ready_i(mw_ready_i), .mw_beat_cnt_o(mw_beat_cnt_o), .error_o(error_o)
  );
  always #5 clk = ~clk;
  int errors = 0;
  int checks = 0;
  task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  beat_t        q [N][$];
  logic [7:0]   cnt_m = '0;
  logic         err_m = 1'b0;
  logic [3:0]   rdy_m, lasts_m;
  logic         vld_m;
  logic [255:0] exp_data;
  logic [31:0]  exp_strb;
  always @(negedge clk) begin
    if (!rst_ni || flush) begin
      for (int i = 0; i < N; i++) q[i].delete();
      cnt_m = '0;
      err_m = 1'b0;
    end else begin
      vld_m = 1'b1;
      for (int i = 0; i < N; i++) begin
        rdy_m[i] = q[i].size() != 4;
        vld_m &= q[i].size() != 0;
      end
      check("ready", cl_w_ready_o, rdy_m);
      check("valid", mw_valid_o, vld_m);
      check("beat_cnt", mw_beat_cnt_o, cnt_m);
      check("error", error_o, err_m);
      if (vld_m && mw_ready_i) begin
        for (int i = 0; i < N; i++) begin
          exp_data[i*64 +: 64] = q[i][0].data;
          exp_strb[i*8 +: 8]   = q[i][0].strb;
          lasts_m[i]           = q[i][0].last;
        end
        check("data", mw_data_o, exp_data);
        check("strb", mw_strb_o, exp_strb);
        check("last", mw_last_o, q[0][0].last);
        check("user", mw_user_o, q[0][0].user);
`ifdef CLUSTER_W_ALIGNER_LAST_CHECK_EN
        if (lasts_m != 4'h0 && lasts_m != 4'hf) err_m = 1'b1;
`endif
        cnt_m = q[0][0].last ? 8'd0 : cnt_m + 8'd1;
        for (int i = 0; i < N; i++) void'(q[i].pop_front());
      end
      for (int i = 0; i < N; i++)
        if (cl_w_valid_i[i] && rdy_m[i])
          q[i].push_back(beat_t'{cl_w_data_i[i*64 +: 64], cl_w_strb_i[i*8 +: 8], cl_w_last_i[i], cl_w_user_i[i]});
    end
  end
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [3:0] v, input logic [3:0] l);
    for (int i = 0; i < N; i++) begin
      cl_w_data_i[i*64 +: 64] = {$urandom, $urandom};
      cl_w_strb_i[i*8 +: 8]   = 8'($urandom);
      cl_w_user_i[i]          = 1'($urandom);
    end
    cl_w_last_i  = l;
    cl_w_valid_i = v;
    idle(1);
    cl_w_valid_i = '0;
  endtask
  initial begin
    #12;
    check("rst_valid", mw_valid_o, 0);
    check("rst_ready", cl_w_ready_o, 4'hf);
    check("rst_cnt", mw_beat_cnt_o, 0);
    check("rst_error", error_o, 0);
    idle(1);
    rst_ni = 1'b1;
    mw_ready_i = 1'b1;
    cl_w_data_i = {64'd4, 64'd3, 64'd2, 64'd1};
    cl_w_valid_i = 4'hf;
    idle(1);
    cl_w_valid_i = '0;
    check("t1_valid", mw_valid_o, 1);
    check("t1_data", mw_data_o, {64'd4, 64'd3, 64'd2, 64'd1});
    idle(1);
    check("t1_empty", mw_valid_o, 0);
    drive(4'b0111, 4'h0);
    for (int k = 0; k < 2; k++) begin
      check("t2_hold", mw_valid_o, 0);
      idle(1);
    end
    drive(4'b1000, 4'h0);
    check("t2_valid", mw_valid_o, 1);
    idle(1);
    check("t2_once", mw_valid_o, 0);
    mw_ready_i = 1'b0;
    repeat (5) drive(4'hf, 4'h0);
    check("t3_full", cl_w_ready_o, 4'h0);
    mw_ready_i = 1'b1;
    idle(4);
    check("t3_drained", mw_valid_o, 0);
    drive(4'hf, 4'h0);
    drive(4'hf, 4'h0);
    drive(4'hf, 4'hf);
    idle(1);
    check("t4_cnt_after", mw_beat_cnt_o, 0);
    drive(4'hf, 4'b0100);
    idle(1);
`ifdef CLUSTER_W_ALIGNER_LAST_CHECK_EN
    check("t5_err_set", error_o, 1);
    idle(2);
    check("t5_err_sticky", error_o, 1);
`else
    check("t5_err_tied", error_o, 0);
    idle(2);
`endif
    mw_ready_i = 1'b0;
    drive(4'hf, 4'h0);
    flush = 1'b1;
    idle(1);
    flush = 1'b0;
    check("t5_flush_err", error_o, 0);
    check("t5_flush_valid", mw_valid_o, 0);
    check("t5_flush_ready", cl_w_ready_o, 4'hf);
    drive(4'hf, 4'h0);
    drive(4'hf, 4'h0);
    #2 rst_ni = 1'b0;
    #1;
    check("t6_rst_valid", mw_valid_o, 0);
    check("t6_rst_ready", cl_w_ready_o, 4'hf);
    check("t6_rst_cnt", mw_beat_cnt_o, 0);
    idle(1);
    rst_ni = 1'b1;
    idle(2);
    check("t6_no_stale", mw_valid_o, 0);
    mw_ready_i = 1'b1;
    drive(4'hf, 4'hf);
    idle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
